// File: rtl/ysyx_24070017_alu_issue.sv
// rtl/ysyx_24070017_alu_issue.sv - issue/writeback sequencer driving the integer ALU
// Handles RV32I OP, OP-IMM, LUI and AUIPC; every other encoding is flagged illegal.
module ysyx_24070017_alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  output logic [6:0]      alu_opcode,
  output logic [2:0]      alu_funct3,
  output logic [6:0]      alu_funct7,
  output logic [XLEN-1:0] alu_src1,
  output logic [XLEN-1:0] alu_src2,
  input  logic [XLEN-1:0] alu_result,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] wb_pc,
  output logic            illegal
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [1:0]      state;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] pc_q;
  logic [6:0]      opcode_q;
  logic [2:0]      funct3_q;
  logic [6:0]      funct7_q;
  logic [XLEN-1:0] src1_q;
  logic [XLEN-1:0] src2_q;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q;
  logic [XLEN-1:0] wb_pc_q;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;

  logic            dec_illegal;
  logic [6:0]      dec_opcode;
  logic [2:0]      dec_funct3;
  logic [6:0]      dec_funct7;
  logic [XLEN-1:0] dec_src1;
  logic [XLEN-1:0] dec_src2;

  assign opc   = inst_q[6:0];
  assign f3    = inst_q[14:12];
  assign f7    = inst_q[31:25];
  assign rd    = inst_q[11:7];
  assign imm_i = {{(XLEN-12){inst_q[31]}}, inst_q[31:20]};
  assign imm_u = {{(XLEN-32){inst_q[31]}}, inst_q[31:12], 12'b0};

  // LUI and AUIPC reuse the ALU add path (OP-IMM, funct3=000) with imm_u as src2.
  always_comb begin
    dec_illegal = 1'b0;
    dec_opcode  = 7'b0;
    dec_funct3  = 3'b0;
    dec_funct7  = 7'b0;
    dec_src1    = '0;
    dec_src2    = '0;
    case (opc)
      OPC_OP: begin
        dec_opcode = OPC_OP;
        dec_funct3 = f3;
        dec_funct7 = f7;
        dec_src1   = rf_rdata1;
        dec_src2   = rf_rdata2;
        if (f7 == F7_ALT)
          dec_illegal = !(f3 == 3'b000 || f3 == 3'b101);
        else
          dec_illegal = (f7 != 7'b0);
      end
      OPC_OP_IMM: begin
        dec_opcode = OPC_OP_IMM;
        dec_funct3 = f3;
        dec_src1   = rf_rdata1;
        dec_src2   = imm_i;
        if (f3 == 3'b001 || f3 == 3'b101)
          dec_funct7 = f7;
        if (f3 == 3'b001)
          dec_illegal = (f7 != 7'b0);
        else if (f3 == 3'b101)
          dec_illegal = !(f7 == 7'b0 || f7 == F7_ALT);
      end
      OPC_LUI: begin
        dec_opcode = OPC_OP_IMM;
        dec_src2   = imm_u;
      end
      OPC_AUIPC: begin
        dec_opcode = OPC_OP_IMM;
        dec_src1   = pc_q;
        dec_src2   = imm_u;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      inst_q    <= '0;
      pc_q      <= '0;
      opcode_q  <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      wb_pc_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            inst_q <= in_inst;
            pc_q   <= in_pc;
            state  <= S_READ;
          end
        end
        S_READ: begin
          if (dec_illegal) begin
            state <= S_IDLE;
          end else begin
            opcode_q <= dec_opcode;
            funct3_q <= dec_funct3;
            funct7_q <= dec_funct7;
            src1_q   <= dec_src1;
            src2_q   <= dec_src2;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          wb_rd_q   <= rd;
          wb_data_q <= alu_result;
          wb_pc_q   <= pc_q;
          state     <= (rd == 5'd0) ? S_IDLE : S_WB;
        end
        S_WB: begin
          if (wb_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (state == S_IDLE);
  assign rf_raddr1  = inst_q[19:15];
  assign rf_raddr2  = inst_q[24:20];
  assign illegal    = (state == S_READ) && dec_illegal;

  // ALU inputs are quiet outside EXEC so the ALU sees no stale operands.
  assign alu_opcode = (state == S_EXEC) ? opcode_q : 7'b0;
  assign alu_funct3 = (state == S_EXEC) ? funct3_q : 3'b0;
  assign alu_funct7 = (state == S_EXEC) ? funct7_q : 7'b0;
  assign alu_src1   = (state == S_EXEC) ? src1_q : '0;
  assign alu_src2   = (state == S_EXEC) ? src2_q : '0;

  assign wb_valid   = (state == S_WB);
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign wb_pc      = wb_pc_q;

endmodule

// File: tb/tb_ysyx_24070017_alu_issue.sv
// tb/tb_ysyx_24070017_alu_issue.sv - directed vector bench for the ALU issue sequencer
module tb_ysyx_24070017_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [31:0] alu_src1, alu_src2;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        illegal;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ysyx_24070017_alu_issue #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_pc(wb_pc), .illegal(illegal)
  );

  // Static register file: x1=10, x2=3, x6=0x80000000, everything else 0.
  function automatic logic [31:0] rf_model(input logic [4:0] a);
    case (a)
      5'd1:    return 32'd10;
      5'd2:    return 32'd3;
      5'd6:    return 32'h8000_0000;
      default: return 32'd0;
    endcase
  endfunction

  assign rf_rdata1 = rf_model(rf_raddr1);
  assign rf_rdata2 = rf_model(rf_raddr2);

  always_comb begin
    alu_result = 32'd0;
    case (alu_funct3)
      3'b000: alu_result = (alu_opcode == 7'b0110011 && alu_funct7[5]) ?
                           alu_src1 - alu_src2 : alu_src1 + alu_src2;
      3'b001: alu_result = alu_src1 << alu_src2[4:0];
      3'b010: alu_result = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
      3'b011: alu_result = {31'd0, alu_src1 < alu_src2};
      3'b100: alu_result = alu_src1 ^ alu_src2;
      3'b101: alu_result = alu_funct7[5] ? 32'($signed(alu_src1) >>> alu_src2[4:0]) :
                           alu_src1 >> alu_src2[4:0];
      3'b110: alu_result = alu_src1 | alu_src2;
      default: alu_result = alu_src1 & alu_src2;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        ill;
    logic        wb;
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[12];

  // Accept at the edge after this call, then follow READ/EXEC/WB one negedge at a time.
  task automatic run_vec(input vec_t v);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_inst = v.inst; in_pc = v.pc;
    @(negedge clk);
    in_valid = 1'b0;
    chk("read_illegal", {31'd0, illegal}, {31'd0, v.ill});
    chk("read_in_ready", {31'd0, in_ready}, 32'd0);
    chk("read_alu_src2_quiet", alu_src2, 32'd0);
    @(negedge clk);
    if (v.ill) begin
      chk("ill_in_ready", {31'd0, in_ready}, 32'd1);
      chk("ill_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("ill_pulse_done", {31'd0, illegal}, 32'd0);
    end else begin
      chk("exec_opcode", {25'd0, alu_opcode}, {25'd0, v.opc});
      chk("exec_funct7", {25'd0, alu_funct7}, {25'd0, v.f7});
      @(negedge clk);
      if (v.wb) begin
        chk("wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, v.rd});
        chk("wb_data", wb_data, v.data);
        chk("wb_pc", wb_pc, v.pc);
        @(negedge clk);
      end else begin
        chk("x0_no_wb", {31'd0, wb_valid}, 32'd0);
      end
    end
    chk("back_to_idle", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    //            inst          pc            ill   wb    opc         f7          rd  data
    vecs[0]  = '{32'h0050_0093, 32'h0000_1000, 1'b0, 1'b1, 7'b0010011, 7'b0000000, 5'd1, 32'd5};
    vecs[1]  = '{32'h4020_81B3, 32'h0000_1004, 1'b0, 1'b1, 7'b0110011, 7'b0100000, 5'd3, 32'd7};
    vecs[2]  = '{32'h4043_5293, 32'h0000_1008, 1'b0, 1'b1, 7'b0010011, 7'b0100000, 5'd5, 32'hF800_0000};
    vecs[3]  = '{32'h1234_53B7, 32'h0000_100C, 1'b0, 1'b1, 7'b0010011, 7'b0000000, 5'd7, 32'h1234_5000};
    vecs[4]  = '{32'h0000_1417, 32'h0000_0100, 1'b0, 1'b1, 7'b0010011, 7'b0000000, 5'd8, 32'h0000_1100};
    vecs[5]  = '{32'h0020_8233, 32'h0000_2000, 1'b0, 1'b1, 7'b0110011, 7'b0000000, 5'd4, 32'd13};
    vecs[6]  = '{32'h0043_5493, 32'h0000_2004, 1'b0, 1'b1, 7'b0010011, 7'b0000000, 5'd9, 32'h0800_0000};
    vecs[7]  = '{32'h0010_0013, 32'h0000_2008, 1'b0, 1'b0, 7'b0010011, 7'b0000000, 5'd0, 32'd0};
    vecs[8]  = '{32'h0000_0073, 32'h0000_3000, 1'b1, 1'b0, 7'b0,       7'b0,       5'd0, 32'd0};
    vecs[9]  = '{32'h0220_80B3, 32'h0000_3004, 1'b1, 1'b0, 7'b0,       7'b0,       5'd0, 32'd0};
    vecs[10] = '{32'h4020_9093, 32'h0000_3008, 1'b1, 1'b0, 7'b0,       7'b0,       5'd0, 32'd0};
    vecs[11] = '{32'h4020_F1B3, 32'h0000_300C, 1'b1, 1'b0, 7'b0,       7'b0,       5'd0, 32'd0};

    rst = 1'b1; in_valid = 1'b0; in_inst = 32'd0; in_pc = 32'd0; wb_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("reset_illegal", {31'd0, illegal}, 32'd0);
    chk("reset_alu_opcode", {25'd0, alu_opcode}, 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);
    chk("reset_raddr1", {27'd0, rf_raddr1}, 32'd0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Writeback backpressure: add x4,x1,x2 held in WB for 5 cycles.
    wb_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h0020_8233; in_pc = 32'h0000_4000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_wb_valid", {31'd0, wb_valid}, 32'd1);
      chk("bp_wb_rd", {27'd0, wb_rd}, 32'd4);
      chk("bp_wb_data", wb_data, 32'd13);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    chk("bp_still_valid", {31'd0, wb_valid}, 32'd1);
    wb_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle", {31'd0, in_ready}, 32'd1);
    chk("bp_wb_dropped", {31'd0, wb_valid}, 32'd0);

    // Reset during EXEC drops the instruction.
    in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h0000_5000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_exec_opcode", {25'd0, alu_opcode}, 32'h13);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_alu_opcode", {25'd0, alu_opcode}, 32'd0);
    chk("rst_alu_src2", alu_src2, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_pc", wb_pc, 32'd0);
    chk("rst_raddr1", {27'd0, rf_raddr1}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_late_wb", {31'd0, wb_valid}, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ysyx_24070017_alu_issue.md
Name: ysyx_24070017_alu_issue

Overview:
Issue/writeback sequencer that drives the integer ALU. It accepts one RV32I instruction at a time from the fetch side through a valid/ready handshake and reads its source registers. It then generates the ALU opcode, funct3, funct7 and operand inputs, captures the ALU result, and presents a register writeback through a second valid/ready handshake. It handles the OP, OP-IMM, LUI and AUIPC opcodes and flags every other encoding as illegal.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  instruction offered.
in_ready  output  1  block is idle and can accept an instruction.
in_inst  input  32  instruction word.
in_pc  input  32  instruction address.
rf_raddr1  output  5  register-file read address 1, taken from latched inst[19:15].
rf_raddr2  output  5  register-file read address 2, taken from latched inst[24:20].
rf_rdata1  input  32  combinational read data for address 1.
rf_rdata2  input  32  combinational read data for address 2.
alu_opcode  output  7  to ALU.
alu_funct3  output  3  to ALU.
alu_funct7  output  7  to ALU.
alu_src1  output  32  to ALU.
alu_src2  output  32  to ALU.
alu_result  input  32  combinational ALU result.
wb_valid  output  1  writeback offered.
wb_ready  input  1  writeback accepted.
wb_rd  output  5  destination register.
wb_data  output  32  result to write.
wb_pc  output  32  pc of the retiring instruction.
illegal  output  1  one-cycle pulse when an unsupported encoding is detected.

Behaviour:
- Reset: synchronous, active-high.
  - Reset is synchronous and active-high.
  - The FSM goes to IDLE and the instruction in flight is dropped.
  - All outputs reset to 0, except in_ready, which is 1 (IDLE).
  - Reset applied mid-operation in any state has exactly this effect.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: in_ready=1. When in_valid is high, latch in_inst and in_pc and go to READ.
  - READ: drive rf_raddr1/2 and decode.
    - Illegal encoding: pulse illegal for this cycle and go to IDLE.
    - Legal encoding: register the operands, opcode, funct3 and funct7, then go to EXEC.
  - EXEC: drive the ALU from the registered values and capture alu_result into wb_data.
    - rd=x0: go to IDLE with no writeback.
    - Otherwise: go to WB.
  - WB: assert wb_valid. wb_rd, wb_data and wb_pc are held stable while wb_ready=0. Go to IDLE in the cycle wb_ready=1.
- Latency: accept at edge T gives wb_valid=1 during cycle T+3. Throughput is one instruction per 4 cycles when wb_ready is held high.
- in_ready is high only in IDLE. There is no skid buffer.
- ALU outputs are 0 in every state except EXEC.
- Operand generation (imm_i = sign-extended inst[31:20]; imm_u = {inst[31:12], 12'b0}):
  - OP (0110011): src1=rs1, src2=rs2. opcode, funct3 and funct7 are passed through.
  - OP-IMM (0010011): src1=rs1, src2=imm_i, opcode=0010011.
    - funct7 = inst[31:25] when funct3 is 001 or 101.
    - funct7 = 0 for all other funct3 values.
  - LUI (0110111): opcode=0010011, funct3=000, funct7=0, src1=0, src2=imm_u.
  - AUIPC (0010111): same ALU encoding as LUI, with src1=pc and src2=imm_u.
- Illegal encodings:
  - Any opcode other than the four listed.
  - OP with funct7 outside {0000000, 0100000}.
  - OP with funct7=0100000 and funct3 not in {000, 101}.
  - OP-IMM with funct3=001 and inst[31:25]≠0000000.
  - OP-IMM with funct3=101 and inst[31:25] outside {0000000, 0100000}.
  - An illegal instruction never produces a writeback.
- in_valid asserted outside IDLE is ignored.

Test Plan:
- addi x1,x0,5 (0x00500093) accepted at T -> wb_valid in cycle T+3 with wb_rd=1, wb_data=5, wb_pc equal to the accepted pc.
- sub x3,x1,x2 (0x402081B3), register model x1=10, x2=3 -> in EXEC alu_opcode=0110011, alu_funct7=0100000; wb_rd=3, wb_data=7.
- srai x5,x6,4 (0x40435293), x6=0x80000000 -> alu_funct7=0100000; wb_data=0xF8000000. Then lui x7,0x12345 (0x123453B7) -> wb_rd=7, wb_data=0x12345000.
- Writeback backpressure: wb_ready=0 for 5 cycles during WB -> wb_valid, wb_rd and wb_data stable and in_ready=0 throughout; IDLE one cycle after wb_ready=1.
- ecall (0x00000073), and OP with funct7=0000001 (0x022080B3) -> one-cycle illegal pulse in READ, no wb_valid, in_ready=1 two cycles after accept. addi x0,x0,1 -> no wb_valid.
- rst=1 asserted during EXEC -> next cycle in_ready=1 and all other outputs 0; the dropped instruction never writes back.
